layer_sequencer: RTL
====================

# layer_sequencer

Per-layer controller for the fully-connected MLP datapath. It accepts one input frame of `numInput` samples over a valid/ready stream and broadcasts the samples to every neuron of the layer. It then waits for each neuron's single-cycle `outvalid`, captures the neuron outputs, and streams them in neuron order to the next layer over valid/ready. It also flags neurons that time out and `outvalid` pulses that arrive unexpectedly.

## Interface
- `layerNo`, 0: layer index; informational only, reported on no port.
- `numInput`, 64: samples per frame; equals each neuron's `numWeight`; ≥ 1.
- `numNeuron`, 8: neurons in the layer; ≥ 1.
- `dataWidth`, 8: sample and neuron output width.
- `timeout`, 64: maximum WAIT cycles before the error exit; ≥ 8.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in `dataWidth`: input sample.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample.
- `n_data` out `dataWidth`: registered broadcast to all neurons' `myinput`.
- `n_valid` out 1: registered broadcast to all neurons' `myinputValid`.
- `n_out` in `numNeuron*dataWidth`: neuron outputs; neuron k occupies bits [k*dataWidth +: dataWidth].
- `n_outvalid` in `numNeuron`: per-neuron `outvalid` pulses.
- `out_data` out `dataWidth`: output sample.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accepts the output sample.
- `busy` out 1: state ≠ IDLE.
- `frame_count` out 16: completed frames; wraps modulo 2^16.
- `err_timeout` out 1: sticky; set when WAIT times out.
- `err_spurious` out 1: sticky; set on an unexpected `outvalid`.

## Operation
- States: IDLE, FEED, WAIT, DRAIN.
- Accept counter `in_cnt`: `$clog2(numInput+1)` bits.
- Output index `idx`: `$clog2(numNeuron)` bits, minimum 1.
- Capture mask: `numNeuron` bits.
- Output buffer: `numNeuron` × `dataWidth`.
- Wait counter: `$clog2(timeout+1)` bits.

**Input acceptance**
- `in_ready` is combinational: 1 in IDLE and FEED, 0 in WAIT and DRAIN.
- A handshake is `in_valid & in_ready`.
- On each handshake: `n_data <= in_data`, `n_valid <= 1`, `in_cnt++`.
- On all other cycles `n_valid <= 0`; `n_data` holds.

**State transitions**
- IDLE, on the first handshake: go to FEED.
  - Clear the mask, the buffer and `in_cnt`, then count this sample as sample 1.
- FEED: gaps in `in_valid` are allowed; the neuron ignores its internal falling-edge event until its count reaches `numWeight`.
  - The handshake with `in_cnt == numInput-1` accepts the last sample; go to WAIT next cycle.
  - If `numInput == 1`, IDLE goes directly to WAIT.
- WAIT:
  - For every bit k with `n_outvalid[k]=1`: set `mask[k]` and load `buf[k]` from `n_out` slice k.
  - When `(mask | n_outvalid)` is all ones: go to DRAIN next cycle, with the final captures included.
  - The wait counter increments each WAIT cycle. When it reaches `timeout`: set `err_timeout` and go to DRAIN; uncaptured entries read 0.
- DRAIN:
  - `out_valid=1`, `out_data = buf[idx]`; both registered and stable while `out_ready=0`.
  - On `out_valid & out_ready`, `idx++`.
  - On the transfer with `idx == numNeuron-1`: go to IDLE, clear `idx`, `frame_count++`.
- `n_outvalid[k]` asserted in any state other than WAIT, or in WAIT while `mask[k]` is already set:
  - Set `err_spurious`.
  - The pulse is otherwise ignored; no buffer write.
- Error flags clear only on `rst`.

**Reset values** (`rst` asserted, including mid-frame)
- Outputs: `in_ready`=1 (state is IDLE), `n_valid`=0, `n_data`=0, `out_valid`=0, `out_data`=0, `busy`=0, `frame_count`=0, `err_timeout`=0, `err_spurious`=0.
- Internal: state IDLE; counters, mask and buffer cleared.
- A frame aborted mid-way is discarded. The neurons must be reset by the same `rst` to drop their partial sums.

## Timing
- Handshake at cycle t → `n_data`/`n_valid` visible at t+1.
- Last handshake at cycle t → state WAIT at t+1.
- Neuron `outvalid` nominally arrives ~6 cycles after its last `n_valid`.
- Final `outvalid` at cycle w → DRAIN and `out_valid=1` at w+1.
- Output throughput: 1 sample/cycle with `out_ready` held high; frame output spans `numNeuron` cycles.
- No input is accepted during WAIT or DRAIN; frames do not overlap.

## Test plan
(All scenarios use `numInput`=4, `numNeuron`=3, `timeout`=16.)
- **Basic frame:** samples 0x01..0x04 back-to-back; stub neurons return 0x11, 0x22, 0x33 with `outvalid` 6 cycles after the last `n_valid`; `out_ready`=1.
  - Required: `n_valid` high for exactly 4 cycles, each lagging its handshake by 1.
  - Required: `out_data` sequence 0x11, 0x22, 0x33 on consecutive cycles; `frame_count`=1; errors 0.
- **Input gaps and skew:** `in_valid` toggling 1-0-1-0; neurons pulse at different cycles.
  - Required: exactly 4 `n_valid` pulses; DRAIN is entered the cycle after the last pulse; outputs are in neuron order.
- **Backpressure:** `out_ready` low for 5 cycles during DRAIN.
  - Required: `out_data`=0x11 stable with `out_valid`=1 throughout; no skipped or duplicated samples; `in_ready`=0 until IDLE.
- **Timeout:** neuron 2 never pulses.
  - Required: `err_timeout`=1 after 16 WAIT cycles; outputs 0x11, 0x22, 0x00; `frame_count` increments.
- **Spurious pulse:** `n_outvalid[1]` pulsed in IDLE, then twice in WAIT.
  - Required: `err_spurious`=1; the first WAIT value is kept.
- **Async reset mid-DRAIN** after 1 output transfer:
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
  - Required: a subsequent clean frame completes with `frame_count`=1.

Source files
------------

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - per-layer MLP controller: feed one frame to all neurons, collect outputs, stream them in neuron order
module layer_sequencer #(
    parameter int layerNo   = 0,
    parameter int numInput  = 64,
    parameter int numNeuron = 8,
    parameter int dataWidth = 8,
    parameter int timeout   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [dataWidth-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [dataWidth-1:0]           n_data,
    output logic                           n_valid,
    input  logic [numNeuron*dataWidth-1:0] n_out,
    input  logic [numNeuron-1:0]           n_outvalid,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [15:0]                    frame_count,
    output logic                           err_timeout,
    output logic                           err_spurious
);

    localparam int CW = $clog2(numInput + 1);
    localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam int WW = $clog2(timeout + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          in_cnt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_inc;
    logic [WW-1:0]          wait_cnt;
    logic [numNeuron-1:0]   mask;
    logic [dataWidth-1:0]   obuf     [numNeuron];
    logic [dataWidth-1:0]   obuf_nxt [numNeuron];
    logic                   hs;
    logic                   frame_start;
    logic                   all_done;
    logic                   wait_hit;
    logic                   spurious;
    logic                   out_xfer;
    logic                   last_xfer;
    logic                   layer_unused;

    assign layer_unused = layerNo[0];

    assign in_ready    = (state == S_IDLE) || (state == S_FEED);
    assign busy        = (state != S_IDLE);
    assign hs          = in_valid & in_ready;
    assign frame_start = (state == S_IDLE) && hs;
    assign all_done    = &(mask | n_outvalid);
    assign wait_hit    = (wait_cnt == WW'(timeout - 1));
    assign out_xfer    = (state == S_DRAIN) && out_valid && out_ready;
    assign last_xfer   = out_xfer && (idx == IW'(numNeuron - 1));
    assign idx_inc     = idx + IW'(1);

    // Outside WAIT every pulse is unexpected; inside WAIT only repeats are.
    assign spurious = (state == S_WAIT) ? |(n_outvalid & mask) : |n_outvalid;

    always_comb begin
        for (int k = 0; k < numNeuron; k++) begin
            obuf_nxt[k] = obuf[k];
            if ((state == S_WAIT) && n_outvalid[k] && !mask[k])
                obuf_nxt[k] = n_out[k*dataWidth +: dataWidth];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = (numInput == 1) ? S_WAIT : S_FEED;
            S_FEED:  if (hs && (in_cnt == CW'(numInput - 1))) state_nxt = S_WAIT;
            S_WAIT:  if (all_done || wait_hit) state_nxt = S_DRAIN;
            S_DRAIN: if (last_xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_data       <= '0;
            n_valid      <= 1'b0;
            in_cnt       <= '0;
            idx          <= '0;
            wait_cnt     <= '0;
            mask         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            frame_count  <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            for (int k = 0; k < numNeuron; k++) obuf[k] <= '0;
        end else begin
            n_valid <= hs;
            if (hs) n_data <= in_data;

            if (frame_start) begin
                in_cnt   <= CW'(1);
                mask     <= '0;
                wait_cnt <= '0;
                for (int k = 0; k < numNeuron; k++) obuf[k] <= '0;
            end else begin
                if (hs) in_cnt <= in_cnt + CW'(1);
                obuf <= obuf_nxt;
            end

            if (state == S_WAIT) begin
                mask     <= mask | n_outvalid;
                wait_cnt <= wait_cnt + WW'(1);
                if (!all_done && wait_hit) err_timeout <= 1'b1;
                // Final captures of this cycle must reach the first output word.
                if (state_nxt == S_DRAIN) begin
                    out_valid <= 1'b1;
                    out_data  <= obuf_nxt[0];
                    idx       <= '0;
                end
            end

            if (last_xfer) begin
                out_valid   <= 1'b0;
                out_data    <= '0;
                idx         <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (out_xfer) begin
                idx      <= idx_inc;
                out_data <= obuf[idx_inc];
            end

            if (spurious) err_spurious <= 1'b1;
        end
    end

endmodule
